z80fi_insn_monitor: RTL and testbench

- Upstream neighbour of the per-instruction z80fi spec modules.
- Observes the core's M-cycle/T-state trace and instruction-byte stream during one instruction.
- Packs the trace into the z80fi retirement record: insn bytes, length, starting IP, M-cycle types and T-cycle counts.
- Pulses z80fi_valid for one clock when the instruction retires; the formal harness compares the record against whichever spec module asserts spec_valid.

---
 rtl/z80fi_insn_monitor_pkg.sv | 29 ++
 rtl/z80fi_insn_monitor_if.sv | 48 ++++
 rtl/z80fi_mcycle_slots.sv | 85 ++++++++
 rtl/z80fi_insn_monitor.sv | 164 ++++++++++++++++
 tb/tb_z80fi_insn_monitor.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/z80fi_insn_monitor_pkg.sv
// Shared z80fi definitions: M-cycle type codes, record capacities and the
// monitor FSM state type.
package z80fi_insn_monitor_pkg;

    localparam int unsigned Z80FI_MAX_BYTES   = 4;
    localparam int unsigned Z80FI_MAX_MCYCLES = 5;
    localparam int unsigned Z80FI_REC_SLOTS   = 5;

    typedef enum logic [2:0] {
        CYCLE_NONE      = 3'd0,
        CYCLE_M1        = 3'd1,
        CYCLE_MEM_READ  = 3'd2,
        CYCLE_MEM_WRITE = 3'd3,
        CYCLE_IO_READ   = 3'd4,
        CYCLE_IO_WRITE  = 3'd5,
        CYCLE_INTERNAL  = 3'd6,
        CYCLE_INTACK    = 3'd7
    } cycle_e;

    typedef enum logic {
        ST_IDLE,
        ST_COLLECT
    } mon_state_e;

    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

endpackage

// File: rtl/z80fi_insn_monitor_if.sv
// Core trace inputs and z80fi retirement record outputs of the monitor.
interface z80fi_insn_monitor_if #(
    parameter int unsigned MAX_BYTES = 4
);
    logic                   cpu_mcycle_start;
    logic [2:0]             cpu_mcycle_type;
    logic                   cpu_byte_valid;
    logic [7:0]             cpu_byte;
    logic [15:0]            cpu_ip;
    logic                   cpu_insn_done;

    logic                   z80fi_valid;
    logic [8*MAX_BYTES-1:0] z80fi_insn;
    logic [2:0]             z80fi_insn_len;
    logic [15:0]            z80fi_reg_ip_in;
    logic [2:0]             z80fi_mcycle_type1;
    logic [2:0]             z80fi_mcycle_type2;
    logic [2:0]             z80fi_mcycle_type3;
    logic [2:0]             z80fi_mcycle_type4;
    logic [2:0]             z80fi_mcycle_type5;
    logic [2:0]             z80fi_tcycles1;
    logic [2:0]             z80fi_tcycles2;
    logic [2:0]             z80fi_tcycles3;
    logic [2:0]             z80fi_tcycles4;
    logic [2:0]             z80fi_tcycles5;
    logic                   z80fi_overflow;

    modport master (
        output cpu_mcycle_start, cpu_mcycle_type, cpu_byte_valid, cpu_byte,
               cpu_ip, cpu_insn_done,
        input  z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_reg_ip_in,
               z80fi_mcycle_type1, z80fi_mcycle_type2, z80fi_mcycle_type3,
               z80fi_mcycle_type4, z80fi_mcycle_type5,
               z80fi_tcycles1, z80fi_tcycles2, z80fi_tcycles3,
               z80fi_tcycles4, z80fi_tcycles5, z80fi_overflow
    );

    modport slave (
        input  cpu_mcycle_start, cpu_mcycle_type, cpu_byte_valid, cpu_byte,
               cpu_ip, cpu_insn_done,
        output z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_reg_ip_in,
               z80fi_mcycle_type1, z80fi_mcycle_type2, z80fi_mcycle_type3,
               z80fi_mcycle_type4, z80fi_mcycle_type5,
               z80fi_tcycles1, z80fi_tcycles2, z80fi_tcycles3,
               z80fi_tcycles4, z80fi_tcycles5, z80fi_overflow
    );

endinterface

// File: rtl/z80fi_mcycle_slots.sv
// M-cycle slot array: per-slot type and T-state count, slot index,
// saturating T-state counter and M-cycle capacity overflow.
module z80fi_mcycle_slots
    import z80fi_insn_monitor_pkg::*;
#(
    parameter int unsigned N = Z80FI_MAX_MCYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       begin_i,
    input  logic       start_i,
    input  logic       tick_i,
    input  cycle_e     type_i,
    output cycle_e     view_type_o [N],
    output logic [2:0] view_tcyc_o [N],
    output logic       view_ovf_o
);
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    cycle_e           type_q [N];
    cycle_e           type_d [N];
    logic [2:0]       tcyc_q [N];
    logic [2:0]       tcyc_d [N];
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [2:0]       tcount_q, tcount_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        type_d   = type_q;
        tcyc_d   = tcyc_q;
        idx_d    = idx_q;
        tcount_d = tcount_q;
        ovf_d    = ovf_q;

        if (begin_i) begin
            for (int unsigned i = 0; i < N; i++) begin
                type_d[i] = CYCLE_NONE;
                tcyc_d[i] = '0;
            end
            type_d[0] = type_i;
            idx_d     = '0;
            tcount_d  = 3'd1;
            ovf_d     = 1'b0;
        end else if (start_i) begin
            // Past the last slot the extra M-cycles fold into the last slot's count
            if (idx_q == LAST) begin
                ovf_d    = 1'b1;
                tcount_d = sat_inc3(tcount_q);
            end else begin
                tcyc_d[idx_q] = tcount_q;
                idx_d         = idx_q + 1'b1;
                type_d[idx_d] = type_i;
                tcount_d      = 3'd1;
            end
        end else if (tick_i) begin
            tcount_d = sat_inc3(tcount_q);
        end

        // Record view as it would be committed this clock: current slot filled in
        view_type_o        = type_d;
        view_tcyc_o        = tcyc_d;
        view_tcyc_o[idx_d] = tcount_d;
        view_ovf_o         = ovf_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < N; i++) begin
                type_q[i] <= CYCLE_NONE;
                tcyc_q[i] <= '0;
            end
            idx_q    <= '0;
            tcount_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            type_q   <= type_d;
            tcyc_q   <= tcyc_d;
            idx_q    <= idx_d;
            tcount_q <= tcount_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: rtl/z80fi_insn_monitor.sv
// Packs one instruction's M-cycle/T-state trace and byte stream into the
// z80fi retirement record and pulses z80fi_valid when it retires.
module z80fi_insn_monitor
    import z80fi_insn_monitor_pkg::*;
#(
    parameter int unsigned MAX_BYTES   = Z80FI_MAX_BYTES,
    parameter int unsigned MAX_MCYCLES = Z80FI_MAX_MCYCLES
) (
    input logic                clk,
    input logic                reset,
    z80fi_insn_monitor_if.slave bus
);
    localparam int unsigned N_COPY =
        (MAX_MCYCLES < Z80FI_REC_SLOTS) ? MAX_MCYCLES : Z80FI_REC_SLOTS;

    mon_state_e             state_q, state_d;
    logic [8*MAX_BYTES-1:0] bytes_q, bytes_d;
    logic [2:0]             len_q, len_d;
    logic                   bovf_q, bovf_d;
    logic [15:0]            ip_q, ip_d;

    logic                   rec_valid_q, rec_valid_d;
    logic [8*MAX_BYTES-1:0] rec_insn_q, rec_insn_d;
    logic [2:0]             rec_len_q, rec_len_d;
    logic [15:0]            rec_ip_q, rec_ip_d;
    cycle_e                 rec_type_q [Z80FI_REC_SLOTS];
    cycle_e                 rec_type_d [Z80FI_REC_SLOTS];
    logic [2:0]             rec_tcyc_q [Z80FI_REC_SLOTS];
    logic [2:0]             rec_tcyc_d [Z80FI_REC_SLOTS];
    logic                   rec_ovf_q, rec_ovf_d;

    logic                   begin_w, in_collect, commit_w;
    cycle_e                 view_type [MAX_MCYCLES];
    logic [2:0]             view_tcyc [MAX_MCYCLES];
    logic                   slot_ovf;

    assign begin_w    = (state_q == ST_IDLE) && bus.cpu_mcycle_start;
    assign in_collect = (state_q == ST_COLLECT);
    assign commit_w   = bus.cpu_insn_done && (begin_w || in_collect);

    z80fi_mcycle_slots #(
        .N(MAX_MCYCLES)
    ) u_slots (
        .clk         (clk),
        .reset       (reset),
        .begin_i     (begin_w),
        .start_i     (in_collect && bus.cpu_mcycle_start),
        .tick_i      (in_collect),
        .type_i      (cycle_e'(bus.cpu_mcycle_type)),
        .view_type_o (view_type),
        .view_tcyc_o (view_tcyc),
        .view_ovf_o  (slot_ovf)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (bus.cpu_mcycle_start && !bus.cpu_insn_done) state_d = ST_COLLECT;
            ST_COLLECT: if (bus.cpu_insn_done) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bytes_d = bytes_q;
        len_d   = len_q;
        bovf_d  = bovf_q;
        ip_d    = ip_q;

        if (begin_w) begin
            bytes_d = '0;
            len_d   = '0;
            bovf_d  = 1'b0;
            ip_d    = bus.cpu_ip;
            if (bus.cpu_byte_valid) begin
                bytes_d[7:0] = bus.cpu_byte;
                len_d        = 3'd1;
            end
        end else if (in_collect && bus.cpu_byte_valid) begin
            if (len_q < 3'(MAX_BYTES)) begin
                for (int unsigned i = 0; i < MAX_BYTES; i++) begin
                    if (len_q == 3'(i)) bytes_d[8*i +: 8] = bus.cpu_byte;
                end
                len_d = len_q + 3'd1;
            end else begin
                bovf_d = 1'b1;
            end
        end
    end

    always_comb begin
        rec_valid_d = commit_w;
        rec_insn_d  = rec_insn_q;
        rec_len_d   = rec_len_q;
        rec_ip_d    = rec_ip_q;
        rec_type_d  = rec_type_q;
        rec_tcyc_d  = rec_tcyc_q;
        rec_ovf_d   = rec_ovf_q;

        if (commit_w) begin
            rec_insn_d = bytes_d;
            rec_len_d  = len_d;
            rec_ip_d   = ip_d;
            rec_ovf_d  = bovf_d || slot_ovf;
            for (int unsigned i = 0; i < Z80FI_REC_SLOTS; i++) begin
                rec_type_d[i] = CYCLE_NONE;
                rec_tcyc_d[i] = '0;
            end
            for (int unsigned i = 0; i < N_COPY; i++) begin
                rec_type_d[i] = view_type[i];
                rec_tcyc_d[i] = view_tcyc[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bytes_q     <= '0;
            len_q       <= '0;
            bovf_q      <= 1'b0;
            ip_q        <= '0;
            rec_valid_q <= 1'b0;
            rec_insn_q  <= '0;
            rec_len_q   <= '0;
            rec_ip_q    <= '0;
            rec_ovf_q   <= 1'b0;
            for (int unsigned i = 0; i < Z80FI_REC_SLOTS; i++) begin
                rec_type_q[i] <= CYCLE_NONE;
                rec_tcyc_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            bytes_q     <= bytes_d;
            len_q       <= len_d;
            bovf_q      <= bovf_d;
            ip_q        <= ip_d;
            rec_valid_q <= rec_valid_d;
            rec_insn_q  <= rec_insn_d;
            rec_len_q   <= rec_len_d;
            rec_ip_q    <= rec_ip_d;
            rec_type_q  <= rec_type_d;
            rec_tcyc_q  <= rec_tcyc_d;
            rec_ovf_q   <= rec_ovf_d;
        end
    end

    assign bus.z80fi_valid        = rec_valid_q;
    assign bus.z80fi_insn         = rec_insn_q;
    assign bus.z80fi_insn_len     = rec_len_q;
    assign bus.z80fi_reg_ip_in    = rec_ip_q;
    assign bus.z80fi_overflow     = rec_ovf_q;
    assign bus.z80fi_mcycle_type1 = rec_type_q[0];
    assign bus.z80fi_mcycle_type2 = rec_type_q[1];
    assign bus.z80fi_mcycle_type3 = rec_type_q[2];
    assign bus.z80fi_mcycle_type4 = rec_type_q[3];
    assign bus.z80fi_mcycle_type5 = rec_type_q[4];
    assign bus.z80fi_tcycles1     = rec_tcyc_q[0];
    assign bus.z80fi_tcycles2     = rec_tcyc_q[1];
    assign bus.z80fi_tcycles3     = rec_tcyc_q[2];
    assign bus.z80fi_tcycles4     = rec_tcyc_q[3];
    assign bus.z80fi_tcycles5     = rec_tcyc_q[4];

endmodule

// File: tb/tb_z80fi_insn_monitor.sv
// Scoreboard bench for z80fi_insn_monitor using directed instruction traces.
module tb_z80fi_insn_monitor;

    localparam logic [2:0] C_NONE = 3'd0;
    localparam logic [2:0] C_M1   = 3'd1;
    localparam logic [2:0] C_RD   = 3'd2;
    localparam logic [2:0] C_WR   = 3'd3;
    localparam logic [2:0] C_INT  = 3'd6;

    typedef struct packed {
        logic [31:0] insn;
        logic [2:0]  len;
        logic [15:0] ip;
        logic [14:0] ty;   // slot1 in [2:0]
        logic [14:0] tc;   // slot1 in [2:0]
        logic        ovf;
        logic [31:0] cyc;  // clock count at which the valid pulse is expected
    } rec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cyc = '0;
    rec_t        sb [$];
    rec_t        exp_rec;
    logic        armed = 1'b0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    z80fi_insn_monitor_if #(.MAX_BYTES(4)) bus ();

    z80fi_insn_monitor #(
        .MAX_BYTES   (4),
        .MAX_MCYCLES (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic tstate(input logic st, input logic [2:0] ty, input logic bv,
                          input logic [7:0] b, input logic dn, input logic [15:0] ip);
        rec_t e;
        @(negedge clk);
        bus.cpu_mcycle_start = st;
        bus.cpu_mcycle_type  = ty;
        bus.cpu_byte_valid   = bv;
        bus.cpu_byte         = b;
        bus.cpu_insn_done    = dn;
        bus.cpu_ip           = ip;
        if (dn && armed) begin
            e     = exp_rec;
            e.cyc = cyc + 32'd1;
            sb.push_back(e);
            armed = 1'b0;
        end
    endtask

    task automatic idle();
        tstate(1'b0, C_NONE, 1'b0, 8'h00, 1'b0, 16'h0000);
    endtask

    // One M-cycle of n T-states; the byte (if any) appears on T1, done on the last T
    task automatic mcycle(input logic [2:0] ty, input int unsigned n, input logic bv,
                          input logic [7:0] b, input logic dn, input logic [15:0] ip);
        for (int unsigned t = 0; t < n; t++)
            tstate(t == 0, ty, bv && (t == 0), b, dn && (t == n - 1), (t == 0) ? ip : ~ip);
    endtask

    task automatic expect_rec(input logic [31:0] insn, input logic [2:0] len, input logic [15:0] ip,
                              input logic [14:0] ty, input logic [14:0] tc, input logic ovf);
        exp_rec = '{insn: insn, len: len, ip: ip, ty: ty, tc: tc, ovf: ovf, cyc: 32'd0};
        armed   = 1'b1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, bus.z80fi_valid}, 32'd0);
        chk({tag, "_insn"}, bus.z80fi_insn, 32'd0);
        chk({tag, "_len"}, {29'd0, bus.z80fi_insn_len}, 32'd0);
        chk({tag, "_ip"}, {16'd0, bus.z80fi_reg_ip_in}, 32'd0);
        chk({tag, "_types"}, {17'd0, bus.z80fi_mcycle_type5, bus.z80fi_mcycle_type4,
            bus.z80fi_mcycle_type3, bus.z80fi_mcycle_type2, bus.z80fi_mcycle_type1}, 32'd0);
        chk({tag, "_tcyc"}, {17'd0, bus.z80fi_tcycles5, bus.z80fi_tcycles4,
            bus.z80fi_tcycles3, bus.z80fi_tcycles2, bus.z80fi_tcycles1}, 32'd0);
        chk({tag, "_ovf"}, {31'd0, bus.z80fi_overflow}, 32'd0);
    endtask

    // Monitor: pops an expected record for every valid pulse
    initial begin
        rec_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.z80fi_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_valid: got pulse at cycle %0d expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("rec_cycle", cyc, e.cyc);
                    chk("rec_insn", bus.z80fi_insn, e.insn);
                    chk("rec_len", {29'd0, bus.z80fi_insn_len}, {29'd0, e.len});
                    chk("rec_ip", {16'd0, bus.z80fi_reg_ip_in}, {16'd0, e.ip});
                    chk("rec_types", {17'd0, bus.z80fi_mcycle_type5, bus.z80fi_mcycle_type4,
                        bus.z80fi_mcycle_type3, bus.z80fi_mcycle_type2, bus.z80fi_mcycle_type1},
                        {17'd0, e.ty});
                    chk("rec_tcyc", {17'd0, bus.z80fi_tcycles5, bus.z80fi_tcycles4,
                        bus.z80fi_tcycles3, bus.z80fi_tcycles2, bus.z80fi_tcycles1},
                        {17'd0, e.tc});
                    chk("rec_ovf", {31'd0, bus.z80fi_overflow}, {31'd0, e.ovf});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.cpu_mcycle_start = 1'b0;
        bus.cpu_mcycle_type  = C_NONE;
        bus.cpu_byte_valid   = 1'b0;
        bus.cpu_byte         = 8'h00;
        bus.cpu_ip           = 16'h0000;
        bus.cpu_insn_done    = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;
        idle();

        // ADD IX,BC
        mcycle(C_M1, 4, 1'b1, 8'hDD, 1'b0, 16'h1000);
        mcycle(C_M1, 4, 1'b1, 8'h09, 1'b0, 16'h1111);
        mcycle(C_INT, 4, 1'b0, 8'h00, 1'b0, 16'h1111);
        expect_rec(32'h0000_09DD, 3'd2, 16'h1000, {C_NONE, C_INT, C_INT, C_M1, C_M1},
                   {3'd0, 3'd3, 3'd4, 3'd4, 3'd4}, 1'b0);
        mcycle(C_INT, 3, 1'b0, 8'h00, 1'b1, 16'h1111);
        idle();
        idle();

        // Back-to-back NOP then LD A,n
        expect_rec(32'h0000_0000, 3'd1, 16'h2000, {C_NONE, C_NONE, C_NONE, C_NONE, C_M1},
                   {3'd0, 3'd0, 3'd0, 3'd0, 3'd4}, 1'b0);
        mcycle(C_M1, 4, 1'b1, 8'h00, 1'b1, 16'h2000);
        mcycle(C_M1, 4, 1'b1, 8'h3E, 1'b0, 16'h2001);
        expect_rec(32'h0000_553E, 3'd2, 16'h2001, {C_NONE, C_NONE, C_NONE, C_RD, C_M1},
                   {3'd0, 3'd0, 3'd0, 3'd3, 3'd4}, 1'b0);
        mcycle(C_RD, 3, 1'b1, 8'h55, 1'b1, 16'h2222);
        idle();

        // Five bytes: fifth dropped
        mcycle(C_M1, 4, 1'b1, 8'hDD, 1'b0, 16'h3000);
        mcycle(C_M1, 4, 1'b1, 8'hCB, 1'b0, 16'h3333);
        mcycle(C_RD, 3, 1'b1, 8'h05, 1'b0, 16'h3333);
        mcycle(C_RD, 3, 1'b1, 8'h06, 1'b0, 16'h3333);
        expect_rec(32'h0605_CBDD, 3'd4, 16'h3000, {C_RD, C_RD, C_RD, C_M1, C_M1},
                   {3'd3, 3'd3, 3'd3, 3'd4, 3'd4}, 1'b1);
        mcycle(C_RD, 3, 1'b1, 8'hFF, 1'b1, 16'h3333);
        idle();

        // Six M-cycles: sixth folds into slot 5 (3 + 2 T-states)
        mcycle(C_M1, 4, 1'b1, 8'hED, 1'b0, 16'h4000);
        mcycle(C_RD, 3, 1'b0, 8'h00, 1'b0, 16'h4444);
        mcycle(C_RD, 3, 1'b0, 8'h00, 1'b0, 16'h4444);
        mcycle(C_WR, 3, 1'b0, 8'h00, 1'b0, 16'h4444);
        mcycle(C_WR, 3, 1'b0, 8'h00, 1'b0, 16'h4444);
        expect_rec(32'h0000_00ED, 3'd1, 16'h4000, {C_WR, C_WR, C_RD, C_RD, C_M1},
                   {3'd5, 3'd3, 3'd3, 3'd3, 3'd4}, 1'b1);
        mcycle(C_INT, 2, 1'b0, 8'h00, 1'b1, 16'h4444);
        idle();

        // Saturation: 10 T-states in one M-cycle
        expect_rec(32'h0000_0000, 3'd1, 16'h5000, {C_NONE, C_NONE, C_NONE, C_NONE, C_M1},
                   {3'd0, 3'd0, 3'd0, 3'd0, 3'd7}, 1'b0);
        mcycle(C_M1, 10, 1'b1, 8'h00, 1'b1, 16'h5000);
        idle();

        // Reset mid-instruction, with start/done/byte asserted during reset
        mcycle(C_M1, 4, 1'b1, 8'hDD, 1'b0, 16'h6000);
        tstate(1'b1, C_M1, 1'b1, 8'hCB, 1'b0, 16'h6666);
        @(negedge clk);
        reset                = 1'b1;
        bus.cpu_mcycle_start = 1'b1;
        bus.cpu_insn_done    = 1'b1;
        bus.cpu_byte_valid   = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.cpu_mcycle_start = 1'b0;
        bus.cpu_insn_done    = 1'b0;
        bus.cpu_byte_valid   = 1'b0;
        chk_zero("midreset");
        // Done without start in IDLE is ignored
        tstate(1'b0, C_NONE, 1'b0, 8'h00, 1'b1, 16'h0000);
        idle();
        expect_rec(32'h0000_0000, 3'd1, 16'h6100, {C_NONE, C_NONE, C_NONE, C_NONE, C_M1},
                   {3'd0, 3'd0, 3'd0, 3'd0, 3'd4}, 1'b0);
        mcycle(C_M1, 4, 1'b1, 8'h00, 1'b1, 16'h6100);
        idle();

        // Done coincident with start in IDLE
        expect_rec(32'h0000_0076, 3'd1, 16'h7000, {C_NONE, C_NONE, C_NONE, C_NONE, C_M1},
                   {3'd0, 3'd0, 3'd0, 3'd0, 3'd1}, 1'b0);
        tstate(1'b1, C_M1, 1'b1, 8'h76, 1'b1, 16'h7000);
        idle();

        for (int i = 0; i < 20 && sb.size() != 0; i++) idle();
        repeat (3) idle();
        chk("sb_drain", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
